dac_point_sequencer: RTL and testbench

Sits between the line generator and the two-channel MCP4922 DAC driver. It accepts one (x, y, blank) point per handshake and sequences the shared DAC: an X write on axis 0, then a Y write on axis 1. It optionally skips writes whose value is unchanged, applies a programmable dwell for analog settling, and times the beam-blank output around each move.

---
 rtl/vector_pkg.sv | 25 ++
 rtl/dac_axis_writer.sv | 76 +++++++
 rtl/dac_point_sequencer.sv | 123 ++++++++++++
 tb/tb_dac_point_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector display path (line generator,
// point sequencer, DAC driver).
package vector_pkg;

    localparam int unsigned DAC_W = 12;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_X,
        SEQ_Y,
        SEQ_DWELL,
        SEQ_FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_CHK,
        W_GUARD,
        W_WAIT
    } wr_phase_t;

endpackage

// File: rtl/dac_axis_writer.sv
// One CHK/GUARD/WAIT write cycle to the shared DAC, reused for both axes,
// with per-axis last-value tracking for skipping unchanged writes.
module dac_axis_writer
    import vector_pkg::*;
#(
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             axis,
    input  logic [DAC_W-1:0] value,
    input  logic             dac_ready,
    output logic             done,
    output logic [DAC_W-1:0] dac_value,
    output logic             dac_axis,
    output logic             dac_strobe
);

    wr_phase_t        phase, phase_n;
    logic             strobe_n;
    logic             skip;
    logic [1:0]       valid;
    logic [DAC_W-1:0] last_val [2];

    assign skip = SKIP_UNCHANGED && valid[axis] && (last_val[axis] == value);

    always_comb begin
        phase_n  = phase;
        strobe_n = 1'b0;
        done     = 1'b0;
        case (phase)
            W_CHK: begin
                if (skip) begin
                    done    = 1'b1;
                    phase_n = W_IDLE;
                end else if (dac_ready) begin
                    strobe_n = 1'b1;
                    phase_n  = W_GUARD;
                end
            end
            // The driver may still show ready for one cycle after the strobe.
            W_GUARD: phase_n = W_WAIT;
            W_WAIT: begin
                if (dac_ready) begin
                    done    = 1'b1;
                    phase_n = W_IDLE;
                end
            end
            default: ;
        endcase
        // Chaining the next axis straight from done avoids an idle cycle.
        if (start) phase_n = W_CHK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= W_IDLE;
            dac_strobe <= 1'b0;
            dac_value  <= '0;
            dac_axis   <= AXIS_X;
            valid      <= '0;
            for (int unsigned i = 0; i < 2; i++) last_val[i] <= '0;
        end else begin
            phase      <= phase_n;
            dac_strobe <= strobe_n;
            if (strobe_n) begin
                dac_value       <= value;
                dac_axis        <= axis;
                last_val[axis]  <= value;
                valid[axis]     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_point_sequencer.sv
// Accepts (x, y, blank) points and sequences X then Y writes on the shared
// DAC, with optional settle dwell and beam-blank timing around each move.
module dac_point_sequencer
    import vector_pkg::*;
#(
    parameter int unsigned DWELL          = 16,
    parameter int unsigned DWELL_W        = 16,
    parameter bit          SKIP_UNCHANGED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DAC_W-1:0] pt_x,
    input  logic [DAC_W-1:0] pt_y,
    input  logic             pt_blank,
    input  logic             pt_strobe,
    output logic             pt_ready,
    output logic [DAC_W-1:0] dac_value,
    output logic             dac_axis,
    output logic             dac_strobe,
    input  logic             dac_ready,
    output logic             blank_out,
    output logic             busy
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'((DWELL > 0) ? DWELL - 1 : 0);

    seq_state_t       state, state_n;
    logic [DAC_W-1:0] x_q, y_q;
    logic             blank_q;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic             ready_n, blank_n, accept;
    logic             wr_start, wr_done, wr_axis;
    logic [DAC_W-1:0] wr_value;

    assign wr_axis  = (state == SEQ_Y) ? AXIS_Y : AXIS_X;
    assign wr_value = (state == SEQ_Y) ? y_q : x_q;

    dac_axis_writer #(
        .SKIP_UNCHANGED(SKIP_UNCHANGED)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .start     (wr_start),
        .axis      (wr_axis),
        .value     (wr_value),
        .dac_ready (dac_ready),
        .done      (wr_done),
        .dac_value (dac_value),
        .dac_axis  (dac_axis),
        .dac_strobe(dac_strobe)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ready_n  = pt_ready;
        blank_n  = blank_out;
        accept   = 1'b0;
        wr_start = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (pt_strobe && pt_ready) begin
                    accept   = 1'b1;
                    wr_start = 1'b1;
                    ready_n  = 1'b0;
                    state_n  = SEQ_X;
                    if (pt_blank) blank_n = 1'b1;
                end
            end
            SEQ_X: begin
                if (wr_done) begin
                    wr_start = 1'b1;
                    state_n  = SEQ_Y;
                end
            end
            SEQ_Y: begin
                if (wr_done) begin
                    if (DWELL == 0) begin
                        state_n = SEQ_FINISH;
                    end else begin
                        cnt_n   = DWELL_LOAD;
                        state_n = SEQ_DWELL;
                    end
                end
            end
            SEQ_DWELL: begin
                if (cnt == '0) state_n = SEQ_FINISH;
                else           cnt_n   = cnt - DWELL_W'(1);
            end
            SEQ_FINISH: begin
                blank_n = blank_q;
                ready_n = 1'b1;
                state_n = SEQ_IDLE;
            end
            default: state_n = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEQ_IDLE;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            blank_q   <= 1'b1;
            pt_ready  <= 1'b1;
            busy      <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pt_ready  <= ready_n;
            busy      <= ~ready_n;
            blank_out <= blank_n;
            if (accept) begin
                x_q     <= pt_x;
                y_q     <= pt_y;
                blank_q <= pt_blank;
            end
        end
    end

endmodule

// File: tb/tb_dac_point_sequencer.sv
// Directed bench for dac_point_sequencer: one DWELL=4 instance with a DAC
// responder model, one DWELL=0 instance for back-to-back point streaming.
module tb_dac_point_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cyc = 0;

    // DWELL = 4 instance
    logic [11:0] pt_x = '0, pt_y = '0;
    logic        pt_blank = 1'b0, pt_strobe = 1'b0;
    logic        pt_ready, dac_axis, dac_strobe, blank_out, busy;
    logic [11:0] dac_value;
    logic        dac_ready = 1'b1;

    // DWELL = 0 instance
    logic [11:0] pt_x0 = '0, pt_y0 = '0;
    logic        pt_blank0 = 1'b0, pt_strobe0 = 1'b0;
    logic        pt_ready0, dac_axis0, dac_strobe0, blank_out0, busy0;
    logic [11:0] dac_value0;
    logic        dac_ready0 = 1'b1;

    int tests = 0;
    int fails = 0;

    dac_point_sequencer #(.DWELL(4), .DWELL_W(16), .SKIP_UNCHANGED(1'b1)) u_dut (
        .clk(clk), .reset(reset), .pt_x(pt_x), .pt_y(pt_y), .pt_blank(pt_blank),
        .pt_strobe(pt_strobe), .pt_ready(pt_ready), .dac_value(dac_value),
        .dac_axis(dac_axis), .dac_strobe(dac_strobe), .dac_ready(dac_ready),
        .blank_out(blank_out), .busy(busy)
    );

    dac_point_sequencer #(.DWELL(0), .DWELL_W(16), .SKIP_UNCHANGED(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .pt_x(pt_x0), .pt_y(pt_y0), .pt_blank(pt_blank0),
        .pt_strobe(pt_strobe0), .pt_ready(pt_ready0), .dac_value(dac_value0),
        .dac_axis(dac_axis0), .dac_strobe(dac_strobe0), .dac_ready(dac_ready0),
        .blank_out(blank_out0), .busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DAC driver model: optionally holds ready low for 20 cycles after a strobe
    bit stretch = 1'b0;
    int low_cnt = 0;
    always @(posedge clk) begin
        if (dac_strobe && stretch) begin
            low_cnt   <= 20;
            dac_ready <= 1'b0;
        end else if (low_cnt > 1) begin
            low_cnt <= low_cnt - 1;
        end else if (low_cnt == 1) begin
            low_cnt   <= 0;
            dac_ready <= 1'b1;
        end
    end

    // Strobe monitors, sampled away from the active edge
    int          mon_cnt = 0, mon_cyc_x = 0, mon_cyc_y = 0;
    logic [11:0] mon_val = '0, mon_xval = '0;
    logic        mon_axis = 1'b0, prev_strobe = 1'b0;
    int          bad_consec = 0, bad_ready = 0, bad_stable = 0;
    always @(negedge clk) begin
        if (!reset) begin
            mon_val = '0; mon_axis = 1'b0; prev_strobe = 1'b0;
        end else begin
            if (dac_strobe) begin
                mon_cnt++;
                mon_val  = dac_value;
                mon_axis = dac_axis;
                if (dac_axis == 1'b0) begin mon_cyc_x = cyc; mon_xval = dac_value; end
                else mon_cyc_y = cyc;
                if (prev_strobe) bad_consec++;
                if (!dac_ready) bad_ready++;
            end else if (dac_value !== mon_val || dac_axis !== mon_axis) begin
                bad_stable++;
            end
            prev_strobe = dac_strobe;
        end
    end

    int   mon0_cnt = 0, bad0_consec = 0;
    logic prev0 = 1'b0;
    always @(negedge clk) begin
        if (!reset) prev0 = 1'b0;
        else begin
            if (dac_strobe0) begin
                mon0_cnt++;
                if (prev0) bad0_consec++;
            end
            prev0 = dac_strobe0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one point on the DWELL=4 instance and waits (bounded) for pt_ready.
    task automatic send(input logic [11:0] x, input logic [11:0] y, input logic b,
                        input bit pulse_busy, output int acc, output int lat,
                        output logic blank_acc, output bit blank0_seen);
        bit done;
        done = 1'b0;
        blank0_seen = 1'b0;
        @(negedge clk);
        pt_x = x; pt_y = y; pt_blank = b; pt_strobe = 1'b1;
        @(negedge clk);
        pt_strobe = 1'b0;
        acc = cyc;
        blank_acc = blank_out;
        for (int i = 0; i < 200; i++) begin
            if (pt_ready) begin
                pt_strobe = 1'b0;
                done = 1'b1;
                break;
            end
            if (blank_out == 1'b0) blank0_seen = 1'b1;
            if (pulse_busy && (i % 7 == 3)) begin
                pt_strobe = 1'b1;
                pt_x = 12'h555;
            end else begin
                pt_strobe = 1'b0;
            end
            @(negedge clk);
        end
        lat = done ? (cyc - acc) : -1;
    endtask

    initial begin
        int   acc, lat, base, na, nr;
        int   acc6 [3];
        int   rdy6 [3];
        logic blank_acc, prev_rdy;
        bit   b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pt_ready", pt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dac_strobe", dac_strobe, 0);
        check("rst_dac_value", dac_value, 0);
        check("rst_dac_axis", dac_axis, 0);
        check("rst_blank_out", blank_out, 1);

        // 1: full point, both axes written, dwell 4
        base = mon_cnt;
        send(12'h123, 12'h456, 1'b0, 1'b0, acc, lat, blank_acc, b0);
        check("t1_latency", lat, 11);
        check("t1_strobes", mon_cnt - base, 2);
        check("t1_x_strobe_cycle", mon_cyc_x - acc, 1);
        check("t1_xy_spacing", mon_cyc_y - mon_cyc_x, 3);
        check("t1_x_value", mon_xval, 12'h123);
        check("t1_y_value", mon_val, 12'h456);
        check("t1_y_axis", mon_axis, 1);
        check("t1_blank_held_until_finish", b0, 0);
        check("t1_blank_after", blank_out, 0);

        // 2: X unchanged -> skipped
        base = mon_cnt;
        send(12'h123, 12'h789, 1'b0, 1'b0, acc, lat, blank_acc, b0);
        check("t2_strobes", mon_cnt - base, 1);
        check("t2_axis", mon_axis, 1);
        check("t2_value", mon_val, 12'h789);
        check("t2_latency", lat, 9);

        // 3: blanked point
        base = mon_cnt;
        send(12'h000, 12'hFFF, 1'b1, 1'b0, acc, lat, blank_acc, b0);
        check("t3_blank_on_accept", blank_acc, 1);
        check("t3_x_strobe_after_accept", mon_cyc_x - acc, 1);
        check("t3_blank_never_low", b0, 0);
        check("t3_blank_after", blank_out, 1);
        check("t3_strobes", mon_cnt - base, 2);
        check("t3_x_value", mon_xval, 12'h000);
        check("t3_y_value", mon_val, 12'hFFF);

        // 4: slow DAC, strobes during busy ignored
        stretch = 1'b1;
        base = mon_cnt;
        send(12'h200, 12'h300, 1'b0, 1'b1, acc, lat, blank_acc, b0);
        stretch = 1'b0;
        check("t4_latency", lat, 51);
        check("t4_strobes", mon_cnt - base, 2);
        check("t4_x_value", mon_xval, 12'h200);
        check("t4_y_value", mon_val, 12'h300);
        check("t4_blank_after", blank_out, 0);

        // 5: reset during dwell
        @(negedge clk);
        pt_x = 12'h321; pt_y = 12'h654; pt_blank = 1'b0; pt_strobe = 1'b1;
        @(negedge clk);
        pt_strobe = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("t5_pt_ready", pt_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_dac_strobe", dac_strobe, 0);
        check("t5_dac_value", dac_value, 0);
        check("t5_dac_axis", dac_axis, 0);
        check("t5_blank_out", blank_out, 1);
        @(negedge clk);
        reset = 1'b1;
        base = mon_cnt;
        send(12'h321, 12'h654, 1'b0, 1'b0, acc, lat, blank_acc, b0);
        check("t5_strobes_after_reset", mon_cnt - base, 2);
        check("t5_latency", lat, 11);

        // 6: DWELL=0, pt_strobe held high for three points
        base = mon0_cnt;
        na = 0; nr = 0;
        @(negedge clk);
        pt_x0 = 12'h010; pt_y0 = 12'h020; pt_strobe0 = 1'b1;
        prev_rdy = pt_ready0;
        for (int i = 0; i < 80 && nr < 3; i++) begin
            @(negedge clk);
            if (prev_rdy && !pt_ready0 && na < 3) begin
                acc6[na] = cyc;
                na++;
                if (na == 1) begin pt_x0 = 12'h010; pt_y0 = 12'h030; end
                if (na == 3) pt_strobe0 = 1'b0;
            end else if (!prev_rdy && pt_ready0 && nr < 3) begin
                rdy6[nr] = cyc;
                nr++;
            end
            prev_rdy = pt_ready0;
        end
        pt_strobe0 = 1'b0;
        check("t6_points_completed", nr, 3);
        if (nr == 3) begin
            check("t6_latency_full", rdy6[0] - acc6[0], 7);
            check("t6_latency_skip_x", rdy6[1] - acc6[1], 5);
            check("t6_latency_skip_both", rdy6[2] - acc6[2], 3);
            check("t6_gap1", acc6[1] - rdy6[0], 1);
            check("t6_gap2", acc6[2] - rdy6[1], 1);
        end
        check("t6_strobes", mon0_cnt - base, 3);
        check("t6_no_consecutive", bad0_consec, 0);

        check("no_consecutive_strobes", bad_consec, 0);
        check("no_strobe_while_busy", bad_ready, 0);
        check("value_axis_stable", bad_stable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
